mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-1 single-bit mux datapath between four requesters.
- Registers a one-hot grant and drives the mux select so exactly one requester's data reaches the shared output.
- Enforces a bounded hold time so that no requester can starve the others.
- Sits directly in front of the lab's 4-to-1 mux: `sel` connects straight to the mux select input.

Parameters:
- `MAX_HOLD`, default 8: maximum consecutive grant cycles while another request is pending. 0 means unlimited (no preemption).
- `CNT_W`, default 4: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- `clk`: input, 1. Rising-edge clock.
- `rst`: input, 1. Synchronous, active-high reset.
- `req`: input, 4. `req[i]` high means requester i wants the mux; it is held high for the whole transfer.
- `gnt`: output, 4. Registered one-hot grant, or 0 when idle.
- `sel`: output, 2. Binary encoding of `gnt`, feeds the mux select.
- `busy`: output, 1. High when any grant is active; qualifies the mux output.
- `hold_cnt`: output, CNT_W. Cycles the current grant has been held, for debug.

Behaviour:
- Reset: on a `rst` sampled high at a rising edge:
  - `gnt`=0, `sel`=0, `busy`=0, `hold_cnt`=0.
  - Round-robin pointer `last` = 3, so requester 0 has first priority after reset.
  - State = IDLE.
  - This applies mid-grant as well: the grant drops on the same edge.
- States: IDLE (no grant) and OWN (one grant active).
- Pick function: search order is `last`+1, `last`+2, `last`+3, `last`+4, all mod 4. The first index with `req` high wins.
- IDLE:
  - If `req`≠0, the pick winner is granted at the next edge: `gnt`=onehot(w), `sel`=w, `busy`=1, `hold_cnt`=0, `last`=w, state → OWN.
  - Latency is exactly 1 cycle from `req` sampled to `gnt` visible.
- OWN, holder h:
  - `req[h]`=0 (release): re-arbitrate in the same cycle with h excluded.
    - Another request present: its grant appears at the next edge, with no idle bubble.
    - No other request: → IDLE, `gnt`=0, `busy`=0, `sel` keeps its last value.
  - `req[h]`=1 and MAX_HOLD≠0 and `hold_cnt`==MAX_HOLD-1 and another request pending (preemption): grant moves to the pick winner (h excluded) at the next edge and `hold_cnt`=0.
  - `req[h]`=1 and `hold_cnt`==MAX_HOLD-1 and no other request: h keeps the grant and `hold_cnt` reloads to 0.
  - Otherwise: `hold_cnt` increments and saturates at 2^CNT_W-1 when MAX_HOLD=0.
- Simultaneous events:
  - A new request arriving in the same cycle as a release takes part in that cycle's arbitration.
  - Release and preemption in the same cycle are treated as a release.
- Invariants:
  - `gnt` is always one-hot or zero.
  - `sel` == index(`gnt`) whenever `busy`=1.
  - `gnt[i]` is never asserted unless `req[i]` was high in the previous cycle.

Optional Feature:
- Macro: `MUX4_ARB_LOCK_EN`.
- Defined: adds input port `lock` (1 bit).
  - While `lock`=1 and `busy`=1, the preemption rule is suppressed and the holder keeps the grant until it releases `req`.
  - `hold_cnt` keeps counting and saturates at 2^CNT_W-1.
  - `lock` has no effect in IDLE.
- Undefined: no `lock` port; the behaviour is exactly as above.

Decomposition:
- Shared package `mux4_arb_pkg`:
  - Constants `N_REQ`=4 and `SEL_W`=2.
  - State encoding IDLE=1'b0, OWN=1'b1.
  - Function `onehot2bin`.
- Sub-module `rr_pick4`: combinational rotating priority encoder.
  - Inputs: `req[3:0]`, `last[1:0]`, `excl_en`, `excl[1:0]`.
  - Outputs: `win[1:0]`, `any`.
- Top level holds the state, `last`, `hold_cnt` and the output registers.

Test Plan:
- Reset/idle: `rst`=1 for 2 cycles with `req`=4'b1111 → `gnt`=0 and `busy`=0. After `rst` drops, `gnt`=4'b0001 and `sel`=0 one cycle later.
- Rotation: `req`=4'b1111, each holder drops its `req` for 1 cycle after 2 cycles of grant → grant order 0,1,2,3,0 with no idle cycle between grants.
- Preemption: MAX_HOLD=4, `req`=4'b0011 held constantly → requester 0 holds 4 cycles (`hold_cnt` 0..3), then `gnt`=4'b0010 with `sel`=1.
- Sole holder: MAX_HOLD=4, `req`=4'b0100 only → `gnt`=4'b0100 continuously and `hold_cnt` wraps 0,1,2,3,0.
- Release to idle and reset mid-grant:
  - `req`=4'b1000 granted, then `req`→0 → next cycle `gnt`=0, `busy`=0, `sel`=3.
  - Re-grant, then pulse `rst` → `gnt`=0 on the same edge, and the next request from requester 0 wins first.
- With `MUX4_ARB_LOCK_EN`: MAX_HOLD=2, `lock`=1, `req`=4'b0011 → requester 0 holds until `req[0]` drops; `gnt`=4'b0010 one cycle later.

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// Shared constants, state encoding and select/grant conversion helpers for the
// four-way round-robin mux arbiter.
package mux4_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  function automatic logic [SEL_W-1:0] onehot2bin(input logic [N_REQ-1:0] oh);
    logic [SEL_W-1:0] b;
    b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) b = b | SEL_W'(i);
    end
    return b;
  endfunction

  function automatic logic [N_REQ-1:0] bin2onehot(input logic [SEL_W-1:0] b);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[b] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating priority encoder: searches last+1 .. last+4 (mod 4),
// optionally skipping one index, and reports the first requester found.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  input  logic             excl_en,
  input  logic [SEL_W-1:0] excl,
  output logic [SEL_W-1:0] win,
  output logic             any
);

  logic [SEL_W-1:0] w_idx;

  always_comb begin
    win   = '0;
    any   = 1'b0;
    w_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = last + SEL_W'(k);
      if (!any && req[w_idx] && !(excl_en && (w_idx == excl))) begin
        any = 1'b1;
        win = w_idx;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 mux select, with a bounded hold time
// so no requester starves the others; MUX4_ARB_LOCK_EN adds a lock input that suppresses preemption.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
`ifdef MUX4_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  arb_state_t       r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [SEL_W-1:0] r_sel;
  logic             r_busy;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [SEL_W-1:0] r_last;

  logic [SEL_W-1:0] w_holder;
  logic             w_own;
  logic             w_release;
  logic             w_lock;
  logic             w_hold_limit;
  logic [SEL_W-1:0] w_win;
  logic             w_any;

`ifdef MUX4_ARB_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  assign w_own     = (r_state == OWN);
  assign w_holder  = onehot2bin(r_gnt);
  assign w_release = w_own && !req[w_holder];
  // >= rather than == so a count that ran past the limit under lock still preempts once lock drops
  assign w_hold_limit = (MAX_HOLD != 0) && (r_hold_cnt >= HOLD_LAST) && !w_lock;

  // While owning, the holder is always excluded: on release it no longer wants the
  // mux, on preemption it must yield to someone else.
  rr_pick4 u_pick (
    .req     (req),
    .last    (r_last),
    .excl_en (w_own),
    .excl    (w_holder),
    .win     (w_win),
    .any     (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_sel      <= '0;
      r_busy     <= 1'b0;
      r_hold_cnt <= '0;
      r_last     <= SEL_W'(N_REQ - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state    <= OWN;
            r_gnt      <= bin2onehot(w_win);
            r_sel      <= w_win;
            r_busy     <= 1'b1;
            r_hold_cnt <= '0;
            r_last     <= w_win;
          end
        end
        OWN: begin
          if (w_release) begin
            if (w_any) begin
              r_gnt      <= bin2onehot(w_win);
              r_sel      <= w_win;
              r_hold_cnt <= '0;
              r_last     <= w_win;
            end else begin
              r_state    <= IDLE;
              r_gnt      <= '0;
              r_busy     <= 1'b0;
              r_hold_cnt <= '0;
            end
          end else if (w_hold_limit) begin
            if (w_any) begin
              r_gnt  <= bin2onehot(w_win);
              r_sel  <= w_win;
              r_last <= w_win;
            end
            r_hold_cnt <= '0;
          end else if (r_hold_cnt != '1) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign sel      = r_sel;
  assign busy     = r_busy;
  assign hold_cnt = r_hold_cnt;

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(r_gnt));
  a_sel_matches : assert property (@(posedge clk) disable iff (rst)
                                   r_busy |-> (r_gnt == bin2onehot(r_sel)));
  a_busy_gnt    : assert property (@(posedge clk) disable iff (rst) r_busy == (r_gnt != '0));

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (MAX_HOLD=4); the lock scenario runs only when MUX4_ARB_LOCK_EN is defined.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       lock;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic [3:0] hold_cnt;

  int n_checks;
  int n_pass;

  mux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
`ifdef MUX4_ARB_LOCK_EN
    .lock     (lock),
`endif
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .hold_cnt (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    lock = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    tick();
    tick();
    n_checks++;
    if ({gnt, sel, busy, hold_cnt} !== {4'b0000, 2'd0, 1'b0, 4'd0})
      $display("FAIL reset_state: got gnt=%b sel=%0d busy=%b hold=%0d, expected gnt=0000 sel=0 busy=0 hold=0",
               gnt, sel, busy, hold_cnt);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({gnt, sel, busy, hold_cnt} !== {4'b0001, 2'd0, 1'b1, 4'd0})
      $display("FAIL reset_first_grant: got gnt=%b sel=%0d busy=%b hold=%0d, expected gnt=0001 sel=0 busy=1 hold=0",
               gnt, sel, busy, hold_cnt);
    else n_pass++;
  endtask

  task automatic test_rotation();
    logic [3:0] cur_oh;
    logic [3:0] nxt_oh;
    logic [1:0] nxt;
    do_reset();
    req = 4'b1111;
    tick();
    n_checks++;
    if (gnt !== 4'b0001)
      $display("FAIL rotation_start: got gnt=%b, expected 0001", gnt);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cur_oh = 4'b0001 << i;
      nxt    = 2'((i + 1) % 4);
      nxt_oh = 4'b0001 << nxt;
      req = 4'b1111;
      tick();
      n_checks++;
      if ({gnt, busy, hold_cnt} !== {cur_oh, 1'b1, 4'd1})
        $display("FAIL rotation_hold%0d: got gnt=%b busy=%b hold=%0d, expected gnt=%b busy=1 hold=1",
                 i, gnt, busy, hold_cnt, cur_oh);
      else n_pass++;
      req = 4'b1111 & ~cur_oh;
      tick();
      n_checks++;
      if ({gnt, sel, busy, hold_cnt} !== {nxt_oh, nxt, 1'b1, 4'd0})
        $display("FAIL rotation_next%0d: got gnt=%b sel=%0d busy=%b hold=%0d, expected gnt=%b sel=%0d busy=1 hold=0",
                 i, gnt, sel, busy, hold_cnt, nxt_oh, nxt);
      else n_pass++;
    end
  endtask

  task automatic test_preemption();
    do_reset();
    req = 4'b0011;
    tick();
    n_checks++;
    if ({gnt, hold_cnt} !== {4'b0001, 4'd0})
      $display("FAIL preempt_first: got gnt=%b hold=%0d, expected gnt=0001 hold=0", gnt, hold_cnt);
    else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if ({gnt, hold_cnt} !== {4'b0001, 4'(k)})
        $display("FAIL preempt_hold%0d: got gnt=%b hold=%0d, expected gnt=0001 hold=%0d", k, gnt, hold_cnt, k);
      else n_pass++;
    end
    tick();
    n_checks++;
    if ({gnt, sel, busy, hold_cnt} !== {4'b0010, 2'd1, 1'b1, 4'd0})
      $display("FAIL preempt_switch: got gnt=%b sel=%0d busy=%b hold=%0d, expected gnt=0010 sel=1 busy=1 hold=0",
               gnt, sel, busy, hold_cnt);
    else n_pass++;
    tick();
    tick();
    tick();
    tick();
    n_checks++;
    if ({gnt, sel, hold_cnt} !== {4'b0001, 2'd0, 4'd0})
      $display("FAIL preempt_back: got gnt=%b sel=%0d hold=%0d, expected gnt=0001 sel=0 hold=0", gnt, sel, hold_cnt);
    else n_pass++;
  endtask

  task automatic test_sole_holder();
    logic [3:0] exp_hold [6];
    exp_hold = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
    do_reset();
    req = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if ({gnt, sel, busy, hold_cnt} !== {4'b0100, 2'd2, 1'b1, exp_hold[k]})
        $display("FAIL sole_holder%0d: got gnt=%b sel=%0d busy=%b hold=%0d, expected gnt=0100 sel=2 busy=1 hold=%0d",
                 k, gnt, sel, busy, hold_cnt, exp_hold[k]);
      else n_pass++;
    end
  endtask

  task automatic test_release_and_reset();
    do_reset();
    req = 4'b1000;
    tick();
    n_checks++;
    if ({gnt, sel, busy} !== {4'b1000, 2'd3, 1'b1})
      $display("FAIL release_grant3: got gnt=%b sel=%0d busy=%b, expected gnt=1000 sel=3 busy=1", gnt, sel, busy);
    else n_pass++;
    req = 4'b0000;
    tick();
    n_checks++;
    if ({gnt, sel, busy} !== {4'b0000, 2'd3, 1'b0})
      $display("FAIL release_idle: got gnt=%b sel=%0d busy=%b, expected gnt=0000 sel=3 busy=0", gnt, sel, busy);
    else n_pass++;
    req = 4'b0010;
    tick();
    n_checks++;
    if ({gnt, sel, busy} !== {4'b0010, 2'd1, 1'b1})
      $display("FAIL regrant1: got gnt=%b sel=%0d busy=%b, expected gnt=0010 sel=1 busy=1", gnt, sel, busy);
    else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++;
    if ({gnt, sel, busy, hold_cnt} !== {4'b0000, 2'd0, 1'b0, 4'd0})
      $display("FAIL mid_grant_reset: got gnt=%b sel=%0d busy=%b hold=%0d, expected gnt=0000 sel=0 busy=0 hold=0",
               gnt, sel, busy, hold_cnt);
    else n_pass++;
    rst = 1'b0;
    req = 4'b1011;
    tick();
    n_checks++;
    if ({gnt, sel} !== {4'b0001, 2'd0})
      $display("FAIL post_reset_priority: got gnt=%b sel=%0d, expected gnt=0001 sel=0", gnt, sel);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0001;
    tick();
    n_checks++;
    if (gnt !== 4'b0001)
      $display("FAIL b2b_first: got gnt=%b, expected 0001", gnt);
    else n_pass++;
    req = 4'b0100;
    tick();
    n_checks++;
    if ({gnt, sel, busy, hold_cnt} !== {4'b0100, 2'd2, 1'b1, 4'd0})
      $display("FAIL b2b_new_arrival: got gnt=%b sel=%0d busy=%b hold=%0d, expected gnt=0100 sel=2 busy=1 hold=0",
               gnt, sel, busy, hold_cnt);
    else n_pass++;
  endtask

`ifdef MUX4_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    lock = 1'b1;
    req = 4'b0011;
    tick();
    n_checks++;
    if (gnt !== 4'b0001)
      $display("FAIL lock_first: got gnt=%b, expected 0001", gnt);
    else n_pass++;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if ({gnt, hold_cnt} !== {4'b0001, 4'(k)})
        $display("FAIL lock_hold%0d: got gnt=%b hold=%0d, expected gnt=0001 hold=%0d", k, gnt, hold_cnt, k);
      else n_pass++;
    end
    req = 4'b0010;
    tick();
    n_checks++;
    if ({gnt, sel, hold_cnt} !== {4'b0010, 2'd1, 4'd0})
      $display("FAIL lock_release: got gnt=%b sel=%0d hold=%0d, expected gnt=0010 sel=1 hold=0", gnt, sel, hold_cnt);
    else n_pass++;
    lock = 1'b0;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    req      = 4'b0000;
    lock     = 1'b0;
    test_reset();
    test_rotation();
    test_preemption();
    test_sole_holder();
    test_release_and_reset();
    test_back_to_back();
`ifdef MUX4_ARB_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
